// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU operand-fetch/writeback sequencer:
//            opcodes, FSM state encoding, instruction field positions and
//            flag bit positions within the stored FLAGS vector.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU opcodes accepted by the sequencer; every other code is illegal.
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  // Instruction layout: {opcode[12:9], rd[8:6], rs1[5:3], rs2[2:0]}
  localparam int INSTR_W = 13;
  localparam int OPC_MSB = 12;
  localparam int OPC_LSB = 9;
  localparam int RD_MSB  = 8;
  localparam int RD_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 3;
  localparam int RS2_MSB = 2;
  localparam int RS2_LSB = 0;

  // Bit positions inside FLAGS = {CF, OF, SF, ZF}
  localparam int FLAG_CF = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_SF = 1;
  localparam int FLAG_ZF = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Legal opcodes form the contiguous range ADD..NOT.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : alu_regfile
// Purpose  : NREGS x WIDTH register file for the ALU sequencer. One
//            synchronous write port shared between host preload and ALU
//            writeback, two synchronously-read operand ports with a common
//            read enable, and one combinational observation port.
// Ports    : clk, rst                    - clock, sync active-high clear
//            host_we/host_addr/host_data - host write request
//            wb_sel/wb_addr/wb_data      - writeback request (wins the port)
//            rd_en, rs1_addr, rs2_addr   - operand read request
//            rs1_data, rs2_data          - registered operand values
//            obs_addr, obs_data          - combinational observe read
// Revision : 1.0 - initial release
// ============================================================================
module alu_regfile #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [WIDTH-1:0] host_data,
  input  logic             wb_sel,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  input  logic [AW-1:0]    obs_addr,
  output logic [WIDTH-1:0] obs_data
);

  logic [WIDTH-1:0] regs [NREGS];

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  // The sequencer never raises both requests in the same cycle (host writes
  // are gated to IDLE, writeback happens in CAPTURE); writeback still takes
  // the port so a stray host request can never corrupt a result.
  always_comb begin
    we    = wb_sel | host_we;
    waddr = wb_sel ? wb_addr : host_addr;
    wdata = wb_sel ? wb_data : host_data;
  end

  // Operand reads sample the array before this edge's write lands, so an
  // accept coinciding with a host write sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      if (rd_en) begin
        rs1_data <= regs[rs1_addr];
        rs2_data <= regs[rs2_addr];
      end
    end
  end

  assign obs_data = regs[obs_addr];

endmodule : alu_regfile
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Operand-fetch / writeback stage wrapped around an 8-bit ALU.
//            Accepts one register-to-register instruction per VALID/READY
//            handshake, fetches operands from an internal register file,
//            drives the ALU through ISSUE (EN) and CAPTURE (OE), then writes
//            the result and flags back. Host can preload registers in IDLE.
// Ports    : CLK, RST                      - clock, sync active-high reset
//            INSTR_VALID/INSTR_READY/INSTR - instruction handshake
//            WR_EN/WR_ADDR/WR_DATA         - host register write
//            RD_ADDR/RD_DATA               - combinational register observe
//            ALU_EN/ALU_OE/ALU_OPCODE/ALU_A/ALU_B - to the ALU
//            ALU_RESULT, CF_IN/OF_IN/SF_IN/ZF_IN  - from the ALU
//            FLAGS                         - stored {CF,OF,SF,ZF}
//            DONE, ERR                     - completion / illegal-op pulses
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               WR_EN,
  input  logic [AW-1:0]      WR_ADDR,
  input  logic [WIDTH-1:0]   WR_DATA,
  input  logic [AW-1:0]      RD_ADDR,
  output logic [WIDTH-1:0]   RD_DATA,
  output logic               ALU_EN,
  output logic               ALU_OE,
  output logic [3:0]         ALU_OPCODE,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  input  logic [WIDTH-1:0]   ALU_RESULT,
  input  logic               CF_IN,
  input  logic               OF_IN,
  input  logic               SF_IN,
  input  logic               ZF_IN,
  output logic [3:0]         FLAGS,
  output logic               DONE,
  output logic               ERR
);

  state_t      state;
  state_t      state_nxt;
  logic        en_nxt;
  logic        oe_nxt;
  logic        done_nxt;
  logic        err_nxt;
  logic        accept;
  logic [AW-1:0] rd_q;

  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd;
  logic [AW-1:0] instr_rs1;
  logic [AW-1:0] instr_rs2;

  assign instr_op  = INSTR[OPC_MSB:OPC_LSB];
  assign instr_rd  = INSTR[RD_MSB:RD_LSB];
  assign instr_rs1 = INSTR[RS1_MSB:RS1_LSB];
  assign instr_rs2 = INSTR[RS2_MSB:RS2_LSB];

  assign INSTR_READY = (state == ST_IDLE);
  assign accept      = (state == ST_IDLE) && INSTR_VALID && op_is_legal(instr_op);

  // --------------------------------------------------------------------------
  // Next-state and registered-output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          if (op_is_legal(instr_op)) begin
            state_nxt = ST_ISSUE;
            en_nxt    = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // ALU registers its result at the end of this cycle; present OE next.
        state_nxt = ST_CAPTURE;
        oe_nxt    = 1'b1;
      end
      ST_CAPTURE: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      ALU_EN     <= 1'b0;
      ALU_OE     <= 1'b0;
      ALU_OPCODE <= 4'b0000;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      FLAGS      <= 4'b0000;
      rd_q       <= '0;
    end else begin
      state  <= state_nxt;
      ALU_EN <= en_nxt;
      ALU_OE <= oe_nxt;
      DONE   <= done_nxt;
      ERR    <= err_nxt;
      if (accept) begin
        ALU_OPCODE <= instr_op;
        rd_q       <= instr_rd;
      end
      // Flags are stored exactly as the ALU presents them; on logic ops the
      // ALU itself holds CF/OF, so the previous values carry through here.
      if (state == ST_CAPTURE) begin
        FLAGS[FLAG_CF] <= CF_IN;
        FLAGS[FLAG_OF] <= OF_IN;
        FLAGS[FLAG_SF] <= SF_IN;
        FLAGS[FLAG_ZF] <= ZF_IN;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register file: operands land directly on ALU_A/ALU_B
  // --------------------------------------------------------------------------
  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk       (CLK),
    .rst       (RST),
    .host_we   (WR_EN && (state == ST_IDLE)),
    .host_addr (WR_ADDR),
    .host_data (WR_DATA),
    .wb_sel    (state == ST_CAPTURE),
    .wb_addr   (rd_q),
    .wb_data   (ALU_RESULT),
    .rd_en     (accept),
    .rs1_addr  (instr_rs1),
    .rs2_addr  (instr_rs2),
    .rs1_data  (ALU_A),
    .rs2_data  (ALU_B),
    .obs_addr  (RD_ADDR),
    .obs_data  (RD_DATA)
  );

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Contains a behavioural
//            8-bit ALU (registers on EN, drives result on OE, holds CF/OF on
//            logic ops) and a reference model of the register file / flags.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [12:0] instr;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        alu_en;
  logic        alu_oe;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        cf_q, of_q, sf_q, zf_q;
  logic [7:0]  alu_q;
  logic [3:0]  flags;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mreg [8];
  logic [3:0] mflags;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(8), .NREGS(8)) dut (
    .CLK         (clk),
    .RST         (rst),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .INSTR       (instr),
    .WR_EN       (wr_en),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .RD_ADDR     (rd_addr),
    .RD_DATA     (rd_data),
    .ALU_EN      (alu_en),
    .ALU_OE      (alu_oe),
    .ALU_OPCODE  (alu_opcode),
    .ALU_A       (alu_a),
    .ALU_B       (alu_b),
    .ALU_RESULT  (alu_result),
    .CF_IN       (cf_q),
    .OF_IN       (of_q),
    .SF_IN       (sf_q),
    .ZF_IN       (zf_q),
    .FLAGS       (flags),
    .DONE        (done),
    .ERR         (err)
  );

  // Arithmetic definition of the ALU: returns {CF,OF,SF,ZF,result}.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic cfo, input logic ofo);
    logic [8:0] s;
    logic [7:0] r;
    logic       cf, of;
    s  = '0;
    r  = '0;
    cf = cfo;
    of = ofo;
    case (op)
      OP_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[7:0];
        cf = s[8];
        of = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        r  = a - b;
        cf = (a < b);
        of = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      default: r = '0;
    endcase
    return {cf, of, r[7], (r == 8'h00), r};
  endfunction

  // Behavioural ALU: registers on EN, drives the bus only while OE is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      {cf_q, of_q, sf_q, zf_q, alu_q} <= '0;
    end else if (alu_en) begin
      {cf_q, of_q, sf_q, zf_q, alu_q} <= alu_fn(alu_opcode, alu_a, alu_b, cf_q, of_q);
    end
  end
  assign alu_result = alu_oe ? alu_q : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [2:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    #1;
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), mreg[i], tag);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    mreg[a] = d;
  endtask

  // One full instruction through the handshake, with an optional host write
  // on the accept edge. Checks the pipeline timing and the writeback result.
  task automatic run_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic hw, input logic [2:0] ha,
                        input logic [7:0] hd);
    logic [11:0] r;
    logic [7:0]  ea, eb;
    logic        legal;
    legal = (op >= 4'd2) && (op <= 4'd7);
    chk("ready_before", {31'd0, instr_ready}, 32'd1);
    ea = mreg[rs1];
    eb = mreg[rs2];
    r  = alu_fn(op, ea, eb, mflags[3], mflags[2]);
    instr = {op, rd, rs1, rs2}; instr_valid = 1'b1;
    wr_en = hw; wr_addr = ha; wr_data = hd;
    tick();
    instr_valid = 1'b0; wr_en = 1'b0;
    if (hw) mreg[ha] = hd;
    if (!legal) begin
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_ready", {31'd0, instr_ready}, 32'd1);
      chk("err_no_en", {31'd0, alu_en}, 32'd0);
      tick();
      chk("err_once", {31'd0, err}, 32'd0);
      chk("err_no_en2", {31'd0, alu_en}, 32'd0);
      chk("err_flags", {28'd0, flags}, {28'd0, mflags});
      return;
    end
    chk("issue_en", {31'd0, alu_en}, 32'd1);
    chk("issue_ready", {31'd0, instr_ready}, 32'd0);
    chk("issue_a", {24'd0, alu_a}, {24'd0, ea});
    chk("issue_b", {24'd0, alu_b}, {24'd0, eb});
    chk("issue_op", {28'd0, alu_opcode}, {28'd0, op});
    tick();
    chk("cap_en", {31'd0, alu_en}, 32'd0);
    chk("cap_oe", {31'd0, alu_oe}, 32'd1);
    chk("cap_ready", {31'd0, instr_ready}, 32'd0);
    chk("cap_done", {31'd0, done}, 32'd0);
    tick();
    mreg[rd] = r[7:0];
    mflags   = r[11:8];
    chk("wb_done", {31'd0, done}, 32'd1);
    chk("wb_ready", {31'd0, instr_ready}, 32'd1);
    chk("wb_oe", {31'd0, alu_oe}, 32'd0);
    chk("wb_flags", {28'd0, flags}, {28'd0, mflags});
    peek(rd, mreg[rd], "wb_rd");
    tick();
    chk("done_once", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [11:0] r;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mflags = 4'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_en", {31'd0, alu_en}, 32'd0);
    chk("rst_oe", {31'd0, alu_oe}, 32'd0);
    chk("rst_opc", {28'd0, alu_opcode}, 32'd0);
    chk("rst_a", {24'd0, alu_a}, 32'd0);
    chk("rst_b", {24'd0, alu_b}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    check_all_regs("rst_reg");

    // 1: ADD overflow into sign bit
    host_write(3'd1, 8'h7F);
    host_write(3'd2, 8'h01);
    run_op(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    peek(3'd3, 8'h80, "t1_r3");
    chk("t1_flags", {28'd0, flags}, 32'b0110);

    // 2: SUB to zero, then SUB with borrow
    run_op(OP_SUB, 3'd4, 3'd1, 3'd1, 1'b0, 3'd0, 8'h00);
    peek(3'd4, 8'h00, "t2_r4");
    chk("t2_flags_a", {28'd0, flags}, 32'b0001);
    run_op(OP_SUB, 3'd5, 3'd2, 3'd1, 1'b0, 3'd0, 8'h00);
    peek(3'd5, 8'h82, "t2_r5");
    chk("t2_flags_b", {28'd0, flags}, 32'b1010);

    // 3: carry-out ADD, then AND must keep CF
    host_write(3'd7, 8'hFF);
    run_op(OP_ADD, 3'd0, 3'd7, 3'd2, 1'b0, 3'd0, 8'h00);
    chk("t3_add_cf", {31'd0, flags[3]}, 32'd1);
    run_op(OP_AND, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    peek(3'd6, 8'h01, "t3_r6");
    chk("t3_flags", {28'd0, flags}, 32'b1000);

    // 4: illegal opcode
    run_op(4'b1001, 3'd1, 3'd1, 3'd2, 1'b0, 3'd0, 8'h00);
    chk("t4_flags", {28'd0, flags}, 32'b1000);
    check_all_regs("t4_reg");

    // 5: VALID held high, three back-to-back R1 = R1 + R2; host write in ISSUE ignored
    instr = {OP_ADD, 3'd1, 3'd1, 3'd2};
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r = alu_fn(OP_ADD, mreg[1], mreg[2], mflags[3], mflags[2]);
      tick();
      chk("t5_en", {31'd0, alu_en}, 32'd1);
      if (k == 0) begin
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
      end
      tick();
      wr_en = 1'b0;
      chk("t5_oe", {31'd0, alu_oe}, 32'd1);
      tick();
      mreg[1] = r[7:0];
      mflags  = r[11:8];
      chk("t5_done", {31'd0, done}, 32'd1);
      chk("t5_flags", {28'd0, flags}, {28'd0, mflags});
      peek(3'd1, 8'h80 + 8'(k), "t5_r1");
    end
    instr_valid = 1'b0;
    tick();
    chk("t5_idle", {31'd0, instr_ready}, 32'd1);
    chk("t5_no_en", {31'd0, alu_en}, 32'd0);

    // 6: reset during CAPTURE drops the instruction
    instr = {OP_ADD, 3'd3, 3'd1, 3'd2};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("t6_in_cap", {31'd0, alu_oe}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    mflags = 4'h0;
    peek(3'd3, 8'h00, "t6_r3");
    chk("t6_flags", {28'd0, flags}, 32'd0);
    chk("t6_oe", {31'd0, alu_oe}, 32'd0);
    chk("t6_en", {31'd0, alu_en}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    chk("t6_done2", {31'd0, done}, 32'd0);
    check_all_regs("t6_reg");

    // Randomized traffic against the reference model
    for (int i = 0; i < 8; i++) host_write(3'(i), 8'($urandom));
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      if ($urandom_range(0, 4) == 0) op = 4'($urandom);
      else op = 4'($urandom_range(2, 7));
      if ($urandom_range(0, 5) == 0) host_write(3'($urandom), 8'($urandom));
      run_op(op, 3'($urandom), 3'($urandom), 3'($urandom),
             ($urandom_range(0, 2) == 0), 3'($urandom), 8'($urandom));
    end
    check_all_regs("rand_reg");
    chk("rand_flags", {28'd0, flags}, {28'd0, mflags});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_alu_sequencer
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Operand-fetch and writeback stage sitting directly upstream and downstream of the 8-bit ALU. Accepts one register-to-register instruction per transaction over a VALID/READY handshake and reads both operands from an internal 8-entry register file. Drives the ALU's EN/OE/OPCODE/A/B, captures its result and CF/OF/SF/ZF flags, and writes the result back. Host preloads registers through a separate write port.

Parameters:
WIDTH, 8, datapath width; must match the ALU's WIDTH.
NREGS, 8, register-file depth; address width is clog2(NREGS).

Ports:
CLK  input  1  single clock; all state changes on posedge.
RST  input  1  synchronous, active-high reset.
INSTR_VALID  input  1  instruction offered.
INSTR_READY  output  1  sequencer can accept an instruction (IDLE only).
INSTR  input  13  {opcode[12:9], rd[8:6], rs1[5:3], rs2[2:0]}.
WR_EN  input  1  host register write.
WR_ADDR  input  3  host write address.
WR_DATA  input  WIDTH  host write data.
RD_ADDR  input  3  observation read address.
RD_DATA  output  WIDTH  combinational read of regfile[RD_ADDR].
ALU_EN  output  1  to ALU EN.
ALU_OE  output  1  to ALU OE.
ALU_OPCODE  output  4  to ALU OPCODE.
ALU_A  output  WIDTH  to ALU A.
ALU_B  output  WIDTH  to ALU B.
ALU_RESULT  input  WIDTH  from ALU ALU_OUT.
CF_IN, OF_IN, SF_IN, ZF_IN  input  1 each  ALU flags.
FLAGS  output  4  stored {CF,OF,SF,ZF}.
DONE  output  1  one-cycle pulse after writeback.
ERR  output  1  one-cycle pulse on illegal opcode.

Behaviour:
- Reset (synchronous, active-high, RST sampled at posedge CLK): state=IDLE; all regfile entries=0; FLAGS=0; ALU_EN=0; ALU_OE=0; ALU_OPCODE=4'b0000; ALU_A=0; ALU_B=0; DONE=0; ERR=0. INSTR_READY=1 in the cycle after reset. Reset in any state drops the in-flight instruction with no writeback.
- Legal opcodes: 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOT (uses rs1 only; rs2 ignored). All others are illegal.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: INSTR_READY=1. On posedge with INSTR_VALID=1:
  - Legal opcode: latch opcode and rd; ALU_A<=reg[rs1], ALU_B<=reg[rs2]; ALU_EN<=1; go to ISSUE.
  - Illegal opcode: ERR<=1 for one cycle, no ALU activity, no register or flag change, stay IDLE.
- ISSUE (1 cycle): ALU_EN=1 with stable OPCODE/A/B; the ALU registers its result at the end of this cycle. Next state: ALU_EN<=0, ALU_OE<=1, go to CAPTURE.
- CAPTURE (1 cycle): ALU_OE=1. At the posedge: reg[rd]<=ALU_RESULT; FLAGS<={CF_IN,OF_IN,SF_IN,ZF_IN}; ALU_OE<=0; DONE<=1 for one cycle; go to IDLE.
- Latency: accept at edge N; writeback at edge N+2; DONE and INSTR_READY high together in the cycle after N+2. Throughput: 1 instruction per 3 cycles with VALID held high.
- Flags are captured exactly as presented. The ALU holds CF/OF on logic ops, so stored CF/OF carry their previous values.
- Host write:
  - Honoured only when state=IDLE; WR_EN in ISSUE or CAPTURE is ignored.
  - WR_EN and instruction accept on the same edge: the write takes effect, and operands latch the pre-write values.
  - rd==rs1 or rd==rs2 is legal; operands are already latched, so there is no hazard.
- RD_DATA is a combinational read and reflects a writeback from the cycle after the edge.
- Register 0 is an ordinary register; it is not hardwired to zero.

Decomposition:
- Package alu_pkg: opcode localparams (ADD..NOT), state enum {IDLE, ISSUE, CAPTURE}, INSTR field bit positions, flag bit indices within FLAGS.
- Sub-module alu_regfile: NREGS x WIDTH, one sync write port with host/writeback mux selected by the FSM, two sync-read operand ports, one combinational observe port, synchronous clear on RST.

Test Plan:
Bench instantiates the real ALU (WIDTH=8) wired to the sequencer.
1. Load R1=0x7F, R2=0x01; ADD rd=3 -> at edge N+2 R3=0x80; FLAGS SF=1, ZF=0, CF=0; DONE pulses exactly 1 cycle; READY low for 2 cycles.
2. SUB rd=4, rs1=1, rs2=1 (R1=0x7F) -> R4=0x00, ZF=1, SF=0, CF=0. Then SUB rd=5, rs1=2, rs2=1 -> R5=0x82, CF=1.
3. AND R1&R2 into R6 after an ADD with CF=1 -> R6=0x01, ZF=0, and CF stays 1 (held through the logic op).
4. INSTR opcode 4'b1001, VALID=1 -> ERR pulse 1 cycle, READY stays 1, ALU_EN never asserts, registers/FLAGS unchanged.
5. VALID held high for three back-to-back ADDs (R1+R2 -> R1) -> R1 goes 0x80, 0x81, 0x82 at 3-cycle spacing; WR_EN to R1 during ISSUE is ignored.
6. Assert RST during CAPTURE of ADD rd=3 -> R3 stays 0 (cleared), FLAGS=0, ALU_OE=0, ALU_EN=0, DONE never pulses, READY=1 the cycle after reset.
